mem_xfer_ctrl: RTL and testbench
================================

Name: mem_xfer_ctrl

Overview:
Sequencing initiator for the single-port synchronous memory block. It drives the memory's read/write/addr/data_in pins and consumes its data_out. It has two jobs:
- LOAD: fill a memory region from a valid/ready input stream.
- DUMP: stream a memory region out on a valid/ready output stream.
It sits between the file/stream front-end and the memory, so the front-end never handles memory timing.

Parameters:
DATA_W, 8, word width; equals the memory's in_width, out_width and mem_width.
ADDR_W, 5, memory address width.
DEPTH, 32, memory words; must equal 2**ADDR_W.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle request; sampled only in IDLE.
mode  input  1  0 = LOAD, 1 = DUMP; latched with start.
base_addr  input  ADDR_W  first address; latched with start.
len  input  ADDR_W+1  words to transfer, 0..DEPTH; latched with start.
busy  output  1  high whenever the FSM is not in IDLE.
done  output  1  one-cycle pulse at the end of a transfer.
s_valid  input  1  input stream valid.
s_ready  output  1  input stream ready.
s_data  input  DATA_W  input stream data.
m_valid  output  1  output stream valid.
m_ready  input  1  output stream ready.
m_data  output  DATA_W  output stream data (registered).
mem_read  output  1  to memory read.
mem_write  output  1  to memory write.
mem_addr  output  ADDR_W  to memory addr.
mem_wdata  output  DATA_W  to memory data_in.
mem_rdata  input  DATA_W  from memory data_out; valid the cycle after mem_read is high.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - busy, done, s_ready, m_valid, mem_read and mem_write are 0.
  - m_data, address and count registers are 0.
  - Memory contents are not touched.
- FSM states: IDLE, LOAD, RD_ISSUE, RD_WAIT, RD_HOLD, DONE.
- IDLE:
  - start=1 latches mode, base_addr into addr, and len into cnt.
  - Next state: DONE if len==0; else LOAD if mode==0; else RD_ISSUE.
  - start is ignored in every other state.
- LOAD:
  - s_ready=1.
  - When s_valid=1, in the same cycle: mem_write=1, mem_addr=addr, mem_wdata=s_data. The memory commits the word at that edge.
  - Each accepted word: addr+1, cnt-1. After the word with cnt==1, go to DONE.
  - Throughput is one word per cycle.
  - s_valid=0 means no write; the FSM holds.
- RD_ISSUE: mem_read=1, mem_addr=addr; go to RD_WAIT.
- RD_WAIT: mem_read=0; mem_rdata is valid this cycle and is registered into m_data; go to RD_HOLD.
- RD_HOLD:
  - m_valid=1; m_data is stable until the handshake.
  - On m_valid&&m_ready: addr+1, cnt-1. Go to DONE if cnt was 1, else RD_ISSUE.
  - Without m_ready, hold with no memory access.
  - Minimum cost is 3 cycles per word.
- DONE: done=1 for exactly one cycle; go to IDLE.
- Address arithmetic is modulo DEPTH: 31+1 wraps to 0. len==DEPTH covers every word exactly once.
- Memory protocol invariants:
  - mem_read and mem_write are never both 1.
  - mem_write is only ever 1 in LOAD.
  - mem_read is only ever 1 in RD_ISSUE.
  - mem_addr and mem_wdata are 0 when neither strobe is high.
- Control outputs (s_ready, m_valid, mem_*) are combinational decodes of state plus the registered addr and m_data. The only input in any combinational path is s_valid/s_data → mem_write/mem_wdata in LOAD.
- busy=1 in every state except IDLE, including DONE.
- If reset is asserted mid-transfer, the transfer is abandoned. Words already written stay in memory, and there is no partial-done pulse.

Decomposition:
- Package mem_xfer_pkg holds:
  - state enum xfer_state_t (6 states);
  - mode enum xfer_mode_t (MODE_LOAD=0, MODE_DUMP=1);
  - default width constants.
- No sub-module: a single FSM plus datapath. The bench instantiates mem_xfer_ctrl together with the existing memory block.

Test Plan:
- LOAD, base 0, len 4, s_data A0,A1,A2,A3, s_valid held high → mem_write high 4 consecutive cycles at addr 0..3; done pulses one cycle after the last write; busy falls the cycle after that.
- DUMP, base 0, len 4, after the load, m_ready=1 → m_data A0..A3 in order; first m_valid 3 cycles after start; mem_read and mem_write never both high.
- LOAD, base 30, len 3, data 11,22,33 → writes land at addr 30, 31, 0. A following DUMP base 30 len 3 returns 11,22,33.
- DUMP with m_ready held low 5 cycles in RD_HOLD → m_valid stays 1, m_data unchanged, no mem_read pulses; on release the next word follows.
- len=0 with start → DONE the next cycle, done=1, no memory strobes. A second start while busy is ignored: no state change, no extra done.
- rst_n pulled low mid-DUMP (word 2 of 4) → busy, m_valid and mem_read drop to 0 immediately, asynchronously. After release a fresh DUMP len 1 returns the correct word.

Source files
------------

// File: rtl/mem_xfer_pkg.sv
// Shared types and default widths for the memory transfer controller.
package mem_xfer_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;
  localparam int DEPTH_DEF  = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RD_HOLD  = 3'd4,
    ST_DONE     = 3'd5
  } xfer_state_t;

  typedef enum logic {
    MODE_LOAD = 1'b0,
    MODE_DUMP = 1'b1
  } xfer_mode_t;

endpackage

// File: rtl/mem_xfer_ctrl.sv
// Sequencing initiator for the single-port synchronous memory.
// LOAD fills a region from the s_* stream; DUMP streams a region out on m_*.
// Addresses wrap modulo DEPTH because DEPTH is 2**ADDR_W and the address
// register is exactly ADDR_W bits wide.
module mem_xfer_ctrl
  import mem_xfer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Largest meaningful length; anything above it would revisit addresses.
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  xfer_state_t       r_state;
  xfer_mode_t        r_mode;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_cnt;
  logic [DATA_W-1:0] r_mData;

  logic [ADDR_W:0]   w_lenClamped;
  logic              w_wrEn;
  logic              w_rdEn;
  logic              w_lastWord;

  // Clamp oversized requests so a transfer never touches a word twice.
  always_comb begin
    w_lenClamped = (len > LEN_MAX) ? LEN_MAX : len;
  end

  // Memory strobes and stream handshakes decoded from the current state.
  always_comb begin
    w_lastWord = (r_cnt == CNT_ONE);
    s_ready    = (r_state == ST_LOAD) && (r_mode == MODE_LOAD);
    w_wrEn     = s_ready && s_valid;
    w_rdEn     = (r_state == ST_RD_ISSUE) && (r_mode == MODE_DUMP);
    m_valid    = (r_state == ST_RD_HOLD);
    busy       = (r_state != ST_IDLE);
    done       = (r_state == ST_DONE);
    mem_write  = w_wrEn;
    mem_read   = w_rdEn;
    mem_addr   = (w_wrEn || w_rdEn) ? r_addr : '0;
    mem_wdata  = w_wrEn ? s_data : '0;
    m_data     = r_mData;
  end

  // Transfer FSM with its address, count and read-data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_LOAD;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_mData <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mode <= xfer_mode_t'(mode);
            r_addr <= base_addr;
            r_cnt  <= w_lenClamped;
            if (w_lenClamped == '0)
              r_state <= ST_DONE;
            else if (mode == MODE_LOAD)
              r_state <= ST_LOAD;
            else
              r_state <= ST_RD_ISSUE;
          end
        end
        ST_LOAD: begin
          if (s_valid) begin
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt - 1'b1;
            if (w_lastWord)
              r_state <= ST_DONE;
          end
        end
        ST_RD_ISSUE: begin
          r_state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          r_mData <= mem_rdata;
          r_state <= ST_RD_HOLD;
        end
        ST_RD_HOLD: begin
          if (m_ready) begin
            r_addr  <= r_addr + 1'b1;
            r_cnt   <= r_cnt - 1'b1;
            r_state <= w_lastWord ? ST_DONE : ST_RD_ISSUE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Bench for mem_xfer_ctrl with a behavioural model of the synchronous memory.
module tb_mem_xfer_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       mode;
  logic [4:0] base_addr;
  logic [5:0] len;
  logic       busy;
  logic       done;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       mem_read;
  logic       mem_write;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] memArray [32];

  int checks;
  int errors;
  int protoViolations;

  typedef struct {
    logic       start;
    logic       mode;
    logic [4:0] base;
    logic [5:0] len;
    logic       sValid;
    logic [7:0] sData;
    logic       mReady;
    logic       eBusy;
    logic       eDone;
    logic       eSReady;
    logic       eMValid;
    logic       eRead;
    logic       eWrite;
    logic [4:0] eAddr;
    logic [7:0] eWdata;
    logic [7:0] eMData;
  } vec_t;

  vec_t vecs [22];

  mem_xfer_ctrl #(.DATA_W(8), .ADDR_W(5), .DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .base_addr(base_addr), .len(len), .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous memory: write commits at the edge, read data next cycle.
  always @(posedge clk) begin
    if (mem_write) memArray[mem_addr] <= mem_wdata;
    if (mem_read) mem_rdata <= memArray[mem_addr];
  end

  // Protocol invariants watched on every cycle outside reset.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_read && mem_write) protoViolations++;
      if (!mem_read && !mem_write && (mem_addr != 5'd0 || mem_wdata != 8'd0)) protoViolations++;
    end
  end

  function automatic vec_t mk(input logic st, input logic md, input logic [4:0] b,
                              input logic [5:0] l, input logic sv, input logic [7:0] sd,
                              input logic mr, input logic eb, input logic ed,
                              input logic esr, input logic emv, input logic erd,
                              input logic ewr, input logic [4:0] ea, input logic [7:0] ewd,
                              input logic [7:0] emd);
    vec_t v;
    v.start = st; v.mode = md; v.base = b; v.len = l;
    v.sValid = sv; v.sData = sd; v.mReady = mr;
    v.eBusy = eb; v.eDone = ed; v.eSReady = esr; v.eMValid = emv;
    v.eRead = erd; v.eWrite = ewr; v.eAddr = ea; v.eWdata = ewd; v.eMData = emd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    start = v.start; mode = v.mode; base_addr = v.base; len = v.len;
    s_valid = v.sValid; s_data = v.sData; m_ready = v.mReady;
  endtask

  task automatic idleInputs();
    start = 1'b0; mode = 1'b0; base_addr = 5'd0; len = 6'd0;
    s_valid = 1'b0; s_data = 8'd0;
  endtask

  // Pulse start for one cycle; returns at the negedge of the first cycle after it.
  task automatic startXfer(input logic md, input logic [4:0] b, input logic [5:0] l);
    @(negedge clk);
    start = 1'b1; mode = md; base_addr = b; len = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic runDump(input string tag, input logic [4:0] b, input int n, input logic [7:0] exp [4]);
    int wait_n;
    m_ready = 1'b1;
    startXfer(1'b1, b, 6'(n));
    for (int k = 0; k < n; k++) begin
      wait_n = 0;
      while (!m_valid && wait_n < 10) begin
        @(negedge clk);
        wait_n++;
      end
      checkOutput($sformatf("%s word%0d valid", tag, k), 32'(m_valid), 32'd1);
      checkOutput($sformatf("%s word%0d data", tag, k), 32'(m_data), 32'(exp[k]));
      @(negedge clk);
    end
    checkOutput($sformatf("%s done", tag), 32'(done), 32'd1);
    @(negedge clk);
    checkOutput($sformatf("%s idle", tag), 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] expW [4];
    int wait_n;
    int reads;
    checks = 0;
    errors = 0;
    protoViolations = 0;
    rst_n = 1'b0;
    m_ready = 1'b0;
    idleInputs();

    // Reset state
    #2;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset s_ready", 32'(s_ready), 32'd0);
    checkOutput("reset m_valid", 32'(m_valid), 32'd0);
    checkOutput("reset mem_read", 32'(mem_read), 32'd0);
    checkOutput("reset mem_write", 32'(mem_write), 32'd0);
    checkOutput("reset m_data", 32'(m_data), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // LOAD base 0 len 4 then DUMP base 0 len 4, cycle by cycle
    //                st md b  l  sv sd     mr  bs dn sr mv rd wr addr  wdata  mdata
    vecs[0]  = mk(1, 0, 0, 4, 0, 8'h00, 0,  0, 0, 0, 0, 0, 0, 5'd0, 8'h00, 8'h00);
    vecs[1]  = mk(0, 0, 0, 0, 1, 8'hA0, 0,  1, 0, 1, 0, 0, 1, 5'd0, 8'hA0, 8'h00);
    vecs[2]  = mk(0, 0, 0, 0, 1, 8'hA1, 0,  1, 0, 1, 0, 0, 1, 5'd1, 8'hA1, 8'h00);
    vecs[3]  = mk(0, 0, 0, 0, 1, 8'hA2, 0,  1, 0, 1, 0, 0, 1, 5'd2, 8'hA2, 8'h00);
    vecs[4]  = mk(0, 0, 0, 0, 1, 8'hA3, 0,  1, 0, 1, 0, 0, 1, 5'd3, 8'hA3, 8'h00);
    vecs[5]  = mk(0, 0, 0, 0, 0, 8'h00, 0,  1, 1, 0, 0, 0, 0, 5'd0, 8'h00, 8'h00);
    vecs[6]  = mk(0, 0, 0, 0, 0, 8'h00, 0,  0, 0, 0, 0, 0, 0, 5'd0, 8'h00, 8'h00);
    vecs[7]  = mk(1, 1, 0, 4, 0, 8'h00, 1,  0, 0, 0, 0, 0, 0, 5'd0, 8'h00, 8'h00);
    vecs[8]  = mk(0, 0, 0, 0, 0, 8'h00, 1,  1, 0, 0, 0, 1, 0, 5'd0, 8'h00, 8'h00);
    vecs[9]  = mk(0, 0, 0, 0, 0, 8'h00, 1,  1, 0, 0, 0, 0, 0, 5'd0, 8'h00, 8'h00);
    vecs[10] = mk(0, 0, 0, 0, 0, 8'h00, 1,  1, 0, 0, 1, 0, 0, 5'd0, 8'h00, 8'hA0);
    vecs[11] = mk(0, 0, 0, 0, 0, 8'h00, 1,  1, 0, 0, 0, 1, 0, 5'd1, 8'h00, 8'hA0);
    vecs[12] = mk(0, 0, 0, 0, 0, 8'h00, 1,  1, 0, 0, 0, 0, 0, 5'd0, 8'h00, 8'hA0);
    vecs[13] = mk(0, 0, 0, 0, 0, 8'h00, 1,  1, 0, 0, 1, 0, 0, 5'd0, 8'h00, 8'hA1);
    vecs[14] = mk(0, 0, 0, 0, 0, 8'h00, 1,  1, 0, 0, 0, 1, 0, 5'd2, 8'h00, 8'hA1);
    vecs[15] = mk(0, 0, 0, 0, 0, 8'h00, 1,  1, 0, 0, 0, 0, 0, 5'd0, 8'h00, 8'hA1);
    vecs[16] = mk(0, 0, 0, 0, 0, 8'h00, 1,  1, 0, 0, 1, 0, 0, 5'd0, 8'h00, 8'hA2);
    vecs[17] = mk(0, 0, 0, 0, 0, 8'h00, 1,  1, 0, 0, 0, 1, 0, 5'd3, 8'h00, 8'hA2);
    vecs[18] = mk(0, 0, 0, 0, 0, 8'h00, 1,  1, 0, 0, 0, 0, 0, 5'd0, 8'h00, 8'hA2);
    vecs[19] = mk(0, 0, 0, 0, 0, 8'h00, 1,  1, 0, 0, 1, 0, 0, 5'd0, 8'h00, 8'hA3);
    vecs[20] = mk(0, 0, 0, 0, 0, 8'h00, 1,  1, 1, 0, 0, 0, 0, 5'd0, 8'h00, 8'hA3);
    vecs[21] = mk(0, 0, 0, 0, 0, 8'h00, 1,  0, 0, 0, 0, 0, 0, 5'd0, 8'h00, 8'hA3);

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].eBusy));
      checkOutput($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].eDone));
      checkOutput($sformatf("vec%0d s_ready", i), 32'(s_ready), 32'(vecs[i].eSReady));
      checkOutput($sformatf("vec%0d m_valid", i), 32'(m_valid), 32'(vecs[i].eMValid));
      checkOutput($sformatf("vec%0d mem_read", i), 32'(mem_read), 32'(vecs[i].eRead));
      checkOutput($sformatf("vec%0d mem_write", i), 32'(mem_write), 32'(vecs[i].eWrite));
      checkOutput($sformatf("vec%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].eAddr));
      checkOutput($sformatf("vec%0d mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].eWdata));
      checkOutput($sformatf("vec%0d m_data", i), 32'(m_data), 32'(vecs[i].eMData));
    end
    idleInputs();
    m_ready = 1'b0;

    // LOAD across the top of the address space: 30, 31, then wrap to 0
    startXfer(1'b0, 5'd30, 6'd3);
    s_valid = 1'b1; s_data = 8'h11; #1;
    checkOutput("wrap write0 addr", 32'(mem_addr), 32'd30);
    @(negedge clk); s_data = 8'h22; #1;
    checkOutput("wrap write1 addr", 32'(mem_addr), 32'd31);
    @(negedge clk); s_data = 8'h33; #1;
    checkOutput("wrap write2 addr", 32'(mem_addr), 32'd0);
    checkOutput("wrap write2 strobe", 32'(mem_write), 32'd1);
    @(negedge clk); s_valid = 1'b0; s_data = 8'h00; #1;
    checkOutput("wrap load done", 32'(done), 32'd1);
    checkOutput("wrap mem30", 32'(memArray[30]), 32'h11);
    checkOutput("wrap mem31", 32'(memArray[31]), 32'h22);
    checkOutput("wrap mem0", 32'(memArray[0]), 32'h33);
    @(negedge clk);
    expW[0] = 8'h11; expW[1] = 8'h22; expW[2] = 8'h33; expW[3] = 8'h00;
    runDump("wrap dump", 5'd30, 3, expW);

    // Back-pressure: word held five cycles with no further memory reads
    m_ready = 1'b0;
    startXfer(1'b1, 5'd0, 6'd2);
    m_ready = 1'b0;
    wait_n = 0;
    while (!m_valid && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    checkOutput("bp first valid", 32'(m_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput($sformatf("bp hold%0d valid", c), 32'(m_valid), 32'd1);
      checkOutput($sformatf("bp hold%0d data", c), 32'(m_data), 32'h33);
      checkOutput($sformatf("bp hold%0d read", c), 32'(mem_read), 32'd0);
    end
    m_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp next issue", 32'(mem_read), 32'd1);
    checkOutput("bp next addr", 32'(mem_addr), 32'd1);
    wait_n = 0;
    while (!m_valid && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    checkOutput("bp word1 data", 32'(m_data), 32'hA1);
    @(negedge clk);
    checkOutput("bp done", 32'(done), 32'd1);
    @(negedge clk);
    m_ready = 1'b0;

    // Zero length goes straight to DONE; a start seen during DONE is ignored
    startXfer(1'b0, 5'd5, 6'd0);
    #1;
    checkOutput("len0 done", 32'(done), 32'd1);
    checkOutput("len0 busy", 32'(busy), 32'd1);
    checkOutput("len0 no write", 32'(mem_write), 32'd0);
    checkOutput("len0 no read", 32'(mem_read), 32'd0);
    start = 1'b1; mode = 1'b1; len = 6'd4;
    @(negedge clk);
    start = 1'b0;
    #1;
    checkOutput("ignored start busy", 32'(busy), 32'd0);
    checkOutput("ignored start done", 32'(done), 32'd0);
    @(negedge clk);
    checkOutput("ignored start still idle", 32'(busy), 32'd0);
    idleInputs();

    // Asynchronous reset during the second read of a four-word DUMP
    m_ready = 1'b1;
    startXfer(1'b1, 5'd0, 6'd4);
    reads = mem_read ? 1 : 0;
    wait_n = 0;
    while (reads < 2 && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
      if (mem_read) reads++;
    end
    checkOutput("rst pre read", 32'(mem_read), 32'd1);
    checkOutput("rst pre busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst async busy", 32'(busy), 32'd0);
    checkOutput("rst async m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst async mem_read", 32'(mem_read), 32'd0);
    checkOutput("rst async done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    expW[0] = 8'hA2; expW[1] = 8'h00; expW[2] = 8'h00; expW[3] = 8'h00;
    runDump("post reset dump", 5'd2, 1, expW);

    checkOutput("protocol violations", 32'(protoViolations), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
